// File: rtl/cluster_decoder768.sv
// cluster_decoder768
//
// Rebuilds a per-frame pad hit map from a stream of cluster words. Words
// arriving between two latch_pulse strobes form one frame. Each accepted word
// marks its pad valid and records the cluster size. When a frame closes, the
// map is copied to the output registers, and frame_valid pulses for one cycle.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   latch_pulse    frame boundary: closes the current frame, opens the next
//   cluster_found  cluster word valid
//   adr[10:0]      cluster pad address (0x7FF = empty word)
//   cnt[2:0]       cluster size minus one
//   pass_in[2:0]   encoder pass tag; expected to count 0..7 per accepted word
//   vpfs_out       valid-pad flags of the last closed frame
//   cnts_out       3-bit count per pad, pad i at [3i+2:3i]
//   frame_valid    one-cycle strobe when the outputs update
//   nclusters      clusters accepted in the last closed frame
//   overflow       last frame had more than MXCLUSTERS clusters
//   adr_err        last frame had a found word with adr >= MXPADS
//   pass_err       last frame had an out-of-sequence pass tag
//
// Optional build macro CLUSTER_EXPAND_EN: an accepted word marks pads
// adr..adr+cnt valid, clipped at the top pad. The count is still stored only
// at adr. When the macro is undefined, only pad adr is marked.
module cluster_decoder768 #(
  parameter int MXPADS     = 768,
  parameter int MXCLUSTERS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  latch_pulse,
  input  logic                  cluster_found,
  input  logic [10:0]           adr,
  input  logic [2:0]            cnt,
  input  logic [2:0]            pass_in,
  output logic [MXPADS-1:0]     vpfs_out,
  output logic [3*MXPADS-1:0]   cnts_out,
  output logic                  frame_valid,
  output logic [3:0]            nclusters,
  output logic                  overflow,
  output logic                  adr_err,
  output logic                  pass_err
);

  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_ACCUM = 1'b1;
  localparam logic [10:0] PAD_LIM = 11'(MXPADS);
  localparam logic [3:0]  CL_LIM  = 4'(MXCLUSTERS);

  logic [0:0]            r_state;
  logic [MXPADS-1:0]     r_acc_vpf;
  logic [3*MXPADS-1:0]   r_acc_cnt;
  logic [3:0]            r_acc_n;
  logic                  r_acc_ovf;
  logic                  r_acc_aerr;
  logic                  r_acc_perr;

  logic                  w_close;
  logic                  w_word;
  logic                  w_in_range;
  logic                  w_accept;
  logic [3:0]            w_base_n;
  logic [11:0]           w_hi;
  logic [MXPADS-1:0]     w_nxt_vpf;
  logic [3*MXPADS-1:0]   w_nxt_cnt;
  logic [3:0]            w_nxt_n;
  logic                  w_nxt_ovf;
  logic                  w_nxt_aerr;
  logic                  w_nxt_perr;

  // A word coincident with the closing latch is applied on top of the cleared
  // accumulator. It therefore becomes the first word of the new frame.
  always_comb begin
    w_close    = (r_state == S_ACCUM) && latch_pulse;
    w_word     = (r_state == S_ACCUM) && cluster_found;
    w_in_range = adr < PAD_LIM;
    w_base_n   = w_close ? 4'd0 : r_acc_n;
    w_accept   = w_word && w_in_range && (w_base_n < CL_LIM);
    w_hi       = {1'b0, adr} + {9'd0, cnt};
    w_nxt_vpf  = w_close ? '0 : r_acc_vpf;
    w_nxt_cnt  = w_close ? '0 : r_acc_cnt;
    for (int i = 0; i < MXPADS; i++) begin
      if (w_accept && (adr == 11'(i))) begin
        w_nxt_vpf[i]       = 1'b1;
        w_nxt_cnt[3*i +: 3] = cnt;
      end
`ifdef CLUSTER_EXPAND_EN
      // The clip at the top pad is implicit: the loop stops at MXPADS-1.
      if (w_accept && (12'(i) >= {1'b0, adr}) && (12'(i) <= w_hi))
        w_nxt_vpf[i] = 1'b1;
`endif
    end
    w_nxt_n    = w_base_n + {3'd0, w_accept};
    w_nxt_ovf  = (!w_close && r_acc_ovf)  || (w_word && w_in_range && (w_base_n >= CL_LIM));
    w_nxt_aerr = (!w_close && r_acc_aerr) || (w_word && !w_in_range);
    // The k-th accepted word must carry pass tag k mod 8.
    w_nxt_perr = (!w_close && r_acc_perr) || (w_accept && (pass_in != w_base_n[2:0]));
  end

  // Accumulator stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc_vpf  <= '0;
      r_acc_cnt  <= '0;
      r_acc_n    <= 4'd0;
      r_acc_ovf  <= 1'b0;
      r_acc_aerr <= 1'b0;
      r_acc_perr <= 1'b0;
    end else begin
      if (latch_pulse) r_state <= S_ACCUM;
      r_acc_vpf  <= w_nxt_vpf;
      r_acc_cnt  <= w_nxt_cnt;
      r_acc_n    <= w_nxt_n;
      r_acc_ovf  <= w_nxt_ovf;
      r_acc_aerr <= w_nxt_aerr;
      r_acc_perr <= w_nxt_perr;
    end
  end

  // Output stage: snapshot of the closed frame, held until the next close
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vpfs_out    <= '0;
      cnts_out    <= '0;
      frame_valid <= 1'b0;
      nclusters   <= 4'd0;
      overflow    <= 1'b0;
      adr_err     <= 1'b0;
      pass_err    <= 1'b0;
    end else begin
      frame_valid <= w_close;
      if (w_close) begin
        vpfs_out  <= r_acc_vpf;
        cnts_out  <= r_acc_cnt;
        nclusters <= r_acc_n;
        overflow  <= r_acc_ovf;
        adr_err   <= r_acc_aerr;
        pass_err  <= r_acc_perr;
      end
    end
  end

endmodule

// File: tb/tb_cluster_decoder768.sv
module tb_cluster_decoder768;

  logic          clock = 1'b0;
  logic          reset;
  logic          latch_pulse;
  logic          cluster_found;
  logic [10:0]   adr;
  logic [2:0]    cnt;
  logic [2:0]    pass_in;
  logic [767:0]  vpfs_out;
  logic [2303:0] cnts_out;
  logic          frame_valid;
  logic [3:0]    nclusters;
  logic          overflow;
  logic          adr_err;
  logic          pass_err;

  int n_cmp = 0;
  int n_bad = 0;

  cluster_decoder768 dut (
    .clock         (clock),
    .reset         (reset),
    .latch_pulse   (latch_pulse),
    .cluster_found (cluster_found),
    .adr           (adr),
    .cnt           (cnt),
    .pass_in       (pass_in),
    .vpfs_out      (vpfs_out),
    .cnts_out      (cnts_out),
    .frame_valid   (frame_valid),
    .nclusters     (nclusters),
    .overflow      (overflow),
    .adr_err       (adr_err),
    .pass_err      (pass_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        f;
    logic [10:0] a;
    logic [2:0]  c;
    logic [2:0]  p;
    int          n;
    logic        aerr;
    logic        perr;
    int          bit_idx;
    logic        bit_exp;
    logic [2:0]  cnt_exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock with the given word/latch on the inputs; sample 1ns after the edge.
  task automatic cyc(input logic f, input logic [10:0] a, input logic [2:0] c,
                     input logic [2:0] p, input logic l);
    cluster_found = f; adr = a; cnt = c; pass_in = p; latch_pulse = l;
    @(posedge clock);
    #1;
    cluster_found = 1'b0; adr = 11'd0; cnt = 3'd0; pass_in = 3'd0; latch_pulse = 1'b0;
  endtask

  // Expected number of valid pads for a single-word frame.
  function automatic int exp_pop(input logic f, input logic [10:0] a, input logic [2:0] c);
    int hi;
    if (!f || a >= 11'd768) return 0;
    hi = int'(a) + int'(c);
    if (hi > 767) hi = 767;
`ifdef CLUSTER_EXPAND_EN
    return hi - int'(a) + 1;
`else
    return (hi >= 0) ? 1 : 0;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vpf"}, 32'(|vpfs_out), 0);
    chk({tag, "_cnt"}, 32'(|cnts_out), 0);
    chk({tag, "_fv"},  32'(frame_valid), 0);
    chk({tag, "_n"},   32'(nclusters), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_aerr"}, 32'(adr_err), 0);
    chk({tag, "_perr"}, 32'(pass_err), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 11'd0,     3'd7, 3'd0, 1, 1'b0, 1'b0, 0,   1'b1, 3'd7};
    tbl[1] = '{1'b1, 11'd767,   3'd3, 3'd0, 1, 1'b0, 1'b0, 767, 1'b1, 3'd3};
    tbl[2] = '{1'b1, 11'd100,   3'd1, 3'd3, 1, 1'b0, 1'b1, 100, 1'b1, 3'd1};
    tbl[3] = '{1'b0, 11'd50,    3'd5, 3'd0, 0, 1'b0, 1'b0, 50,  1'b0, 3'd0};
    tbl[4] = '{1'b1, 11'd768,   3'd0, 3'd0, 0, 1'b1, 1'b0, 767, 1'b0, 3'd0};
    tbl[5] = '{1'b1, 11'h7FF,   3'd2, 3'd0, 0, 1'b1, 1'b0, 767, 1'b0, 3'd0};

    reset = 1'b1; latch_pulse = 1'b0; cluster_found = 1'b0;
    adr = 11'd0; cnt = 3'd0; pass_in = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // IDLE: a word is ignored, and the first latch only opens a frame.
    cyc(1'b1, 11'd3, 3'd0, 3'd0, 1'b0);
    chk("idle_fv", 32'(frame_valid), 0);
    cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
    chk("open_fv", 32'(frame_valid), 0);

    // Single-word frames from the table
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].f, tbl[i].a, tbl[i].c, tbl[i].p, 1'b0);
      cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
      chk($sformatf("t%0d_fv", i),   32'(frame_valid), 1);
      chk($sformatf("t%0d_n", i),    32'(nclusters), 32'(tbl[i].n));
      chk($sformatf("t%0d_aerr", i), 32'(adr_err), 32'(tbl[i].aerr));
      chk($sformatf("t%0d_perr", i), 32'(pass_err), 32'(tbl[i].perr));
      chk($sformatf("t%0d_ovf", i),  32'(overflow), 0);
      chk($sformatf("t%0d_bit", i),  32'(vpfs_out[tbl[i].bit_idx]), 32'(tbl[i].bit_exp));
      chk($sformatf("t%0d_cnt", i),  32'(cnts_out[3*tbl[i].bit_idx +: 3]), 32'(tbl[i].cnt_exp));
      chk($sformatf("t%0d_pop", i),  32'($countones(vpfs_out)), 32'(exp_pop(tbl[i].f, tbl[i].a, tbl[i].c)));
      cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b0);
      chk($sformatf("t%0d_fv_off", i), 32'(frame_valid), 0);
      chk($sformatf("t%0d_hold_n", i), 32'(nclusters), 32'(tbl[i].n));
    end

    // Two-word frame
    cyc(1'b1, 11'd5,   3'd2, 3'd0, 1'b0);
    cyc(1'b1, 11'd700, 3'd0, 3'd1, 1'b0);
    cyc(1'b0, 11'd0,   3'd0, 3'd0, 1'b1);
    chk("two_fv",   32'(frame_valid), 1);
    chk("two_b5",   32'(vpfs_out[5]), 1);
    chk("two_b700", 32'(vpfs_out[700]), 1);
    chk("two_c5",   32'(cnts_out[15 +: 3]), 2);
    chk("two_n",    32'(nclusters), 2);
    chk("two_flags", 32'({overflow, adr_err, pass_err}), 0);
`ifdef CLUSTER_EXPAND_EN
    chk("two_pop",  32'($countones(vpfs_out)), 4);
`else
    chk("two_pop",  32'($countones(vpfs_out)), 2);
`endif

    // Overflow: ten words with correct pass tags
    for (int i = 0; i < 10; i++) cyc(1'b1, 11'(20 + i), 3'd0, 3'(i % 8), 1'b0);
    cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
    chk("ovf_n",    32'(nclusters), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_perr", 32'(pass_err), 0);
    chk("ovf_b20",  32'(vpfs_out[20]), 1);
    chk("ovf_b27",  32'(vpfs_out[27]), 1);
    chk("ovf_b28",  32'(vpfs_out[28]), 0);
    chk("ovf_b29",  32'(vpfs_out[29]), 0);
    chk("ovf_pop",  32'($countones(vpfs_out)), 8);

    // Out-of-range found word, then an unfound empty word
    cyc(1'b1, 11'd768,  3'd0, 3'd0, 1'b0);
    cyc(1'b0, 11'h7FF,  3'd0, 3'd0, 1'b0);
    cyc(1'b0, 11'd0,    3'd0, 3'd0, 1'b1);
    chk("aerr_flag", 32'(adr_err), 1);
    chk("aerr_n",    32'(nclusters), 0);
    chk("aerr_vpf",  32'(|vpfs_out), 0);
    chk("aerr_ovf",  32'(overflow), 0);

    // Word coincident with the closing latch belongs to the next frame
    cyc(1'b1, 11'd10, 3'd0, 3'd0, 1'b1);
    chk("coin_fv",  32'(frame_valid), 1);
    chk("coin_b10", 32'(vpfs_out[10]), 0);
    chk("coin_n",   32'(nclusters), 0);
    chk("coin_aerr", 32'(adr_err), 0);
    cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
    chk("next_fv",  32'(frame_valid), 1);
    chk("next_b10", 32'(vpfs_out[10]), 1);
    chk("next_n",   32'(nclusters), 1);
    chk("next_perr", 32'(pass_err), 0);
    // Back-to-back latch: a further strobe for an empty frame
    cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
    chk("b2b_fv",  32'(frame_valid), 1);
    chk("b2b_n",   32'(nclusters), 0);
    chk("b2b_b10", 32'(vpfs_out[10]), 0);

    // Word near the top of the pad range
    cyc(1'b1, 11'd766, 3'd4, 3'd0, 1'b0);
    cyc(1'b0, 11'd0,   3'd0, 3'd0, 1'b1);
    chk("top_b766", 32'(vpfs_out[766]), 1);
    chk("top_c766", 32'(cnts_out[3*766 +: 3]), 4);
    chk("top_n",    32'(nclusters), 1);
`ifdef CLUSTER_EXPAND_EN
    chk("top_b767", 32'(vpfs_out[767]), 1);
    chk("top_pop",  32'($countones(vpfs_out)), 2);
`else
    chk("top_b767", 32'(vpfs_out[767]), 0);
    chk("top_pop",  32'($countones(vpfs_out)), 1);
`endif

    // Reset mid-frame after three words
    cyc(1'b1, 11'd1, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 11'd2, 3'd0, 3'd1, 1'b0);
    cyc(1'b1, 11'd3, 3'd0, 3'd2, 1'b0);
    reset = 1'b1;
    #2;
    chk_all_zero("arst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
    chk("post_rst_fv", 32'(frame_valid), 0);
    cyc(1'b1, 11'd4, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 11'd0, 3'd0, 3'd0, 1'b1);
    chk("post_fv", 32'(frame_valid), 1);
    chk("post_n",  32'(nclusters), 1);
    chk("post_b4", 32'(vpfs_out[4]), 1);
    chk("post_b1", 32'(vpfs_out[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cluster_decoder768.md
CLUSTER_DECODER768 -- requirements
Module: cluster_decoder768

Interface
REQ-001 Parameter MXPADS, default 768, number of pads in the reconstructed hit map.
REQ-002 Parameter MXCLUSTERS, default 8, maximum clusters accepted per frame.
REQ-003 clock  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 latch_pulse  input  1  frame boundary; closes the current frame and opens the next.
REQ-006 cluster_found  input  1  cluster word valid.
REQ-007 adr  input  11  cluster pad address; 0x7FF marks an empty word.
REQ-008 cnt  input  3  cluster size minus one.
REQ-009 pass_in  input  3  encoder pass tag of the word.
REQ-010 vpfs_out  output  768  reconstructed valid-pad flags for the last closed frame.
REQ-011 cnts_out  output  2304  per-pad 3-bit counts, pad i at bits [3i+2:3i].
REQ-012 frame_valid  output  1  one-cycle strobe; vpfs_out/cnts_out updated.
REQ-013 nclusters  output  4  clusters accepted in the last closed frame.
REQ-014 overflow  output  1  last closed frame received more than MXCLUSTERS clusters.
REQ-015 adr_err  output  1  last closed frame contained a found word with adr >= MXPADS.
REQ-016 pass_err  output  1  last closed frame had a pass_in out of sequence.

Function
REQ-017 States SHALL be IDLE and ACCUM; reset SHALL enter IDLE; the first latch_pulse SHALL move to ACCUM; there is no other transition except reset.
REQ-018 In IDLE, cluster words SHALL be ignored and frame_valid SHALL NOT assert.
REQ-019 In ACCUM, a word with cluster_found=1, adr<MXPADS and accepted count<MXCLUSTERS SHALL set acc_vpf[adr]=1 and acc_cnt[adr]=cnt, and SHALL increment the accepted count.
REQ-020 A duplicate address SHALL overwrite acc_cnt; vpf stays 1; the count still increments.
REQ-021 cluster_found=0 SHALL be ignored regardless of adr and pass_in.
REQ-022 A found word with adr>=MXPADS SHALL set the frame adr_err flag and SHALL NOT be counted.
REQ-023 A valid word arriving with accepted count=MXCLUSTERS SHALL be dropped and SHALL set the frame overflow flag; the count saturates at MXCLUSTERS.
REQ-024 pass_in of the k-th accepted word (k from 0) SHALL equal k mod 8; any mismatch SHALL set the frame pass_err flag and the word SHALL still be written.
REQ-025 On latch_pulse in ACCUM, the accumulator and frame flags SHALL be copied to the outputs on the next edge; frame_valid SHALL be 1 for exactly that cycle.
REQ-026 The accumulator, count and flags SHALL clear on that same edge.
REQ-027 A cluster word coincident with latch_pulse SHALL belong to the new frame; it SHALL be written into the cleared accumulator as its first word.
REQ-028 Outputs SHALL hold between frame_valid strobes.
REQ-029 Latency from the latch_pulse cycle to the frame_valid cycle SHALL be 1 clock.
REQ-030 Back-to-back latch_pulse SHALL produce back-to-back frame_valid strobes; the second strobe reports an empty frame with nclusters=0.

Reset
REQ-031 Reset SHALL asynchronously clear every output to 0: vpfs_out, cnts_out, frame_valid, nclusters, overflow, adr_err and pass_err.
REQ-032 Reset SHALL also clear the accumulator and the state register.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid SHALL assert until after the second latch_pulse following release.

Configuration
REQ-034 Macro CLUSTER_EXPAND_EN defined: an accepted word SHALL set acc_vpf for pads adr through adr+cnt, clipped at MXPADS-1, with acc_cnt written only at adr.
REQ-035 CLUSTER_EXPAND_EN undefined: only acc_vpf[adr] SHALL be set, per REQ-019.

Verification
REQ-036 latch_pulse; words (adr=5,cnt=2,pass=0), (adr=700,cnt=0,pass=1); latch_pulse -> frame_valid one cycle later; vpfs_out bits 5 and 700 set; cnts_out pad5=2; nclusters=2; all flags 0.
REQ-037 Ten valid words, pass 0..7,0,1, in one frame -> nclusters=8, overflow=1; the 9th and 10th addresses are absent from vpfs_out.
REQ-038 Word adr=768, found=1, then word adr=0x7FF, found=0 -> adr_err=1, nclusters=0, vpfs_out all 0.
REQ-039 Word adr=10 coincident with the closing latch_pulse -> pad 10 absent from this frame; pad 10 present in the next frame with nclusters=1.
REQ-040 With CLUSTER_EXPAND_EN: word adr=766, cnt=4 -> vpfs_out bits 766 and 767 set only; cnts_out pad766=4.
REQ-041 Reset pulse asserted mid-frame after 3 words -> all outputs 0 immediately; first post-reset latch_pulse yields no frame_valid.
